alu_seq: RTL and testbench

- Parametrised, clocked, multi-cycle successor to the team's combinational 32-bit ALU. Opcode map and `out`/`ack` naming are unchanged.
- Operands are captured on a request. Multiply, divide and modulo run iteratively over WIDTH cycles; all other ops complete in one cycle.
- Result is returned with a one-cycle `ack` pulse. Sits between the datapath controller and the register file as a shared arithmetic resource.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_seq_iter.sv | 79 +++++++
 rtl/alu_seq.sv | 144 ++++++++++++++
 tb/tb_alu_seq.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Opcode map, FSM state encoding and iteration-counter sizing shared by alu_seq and alu_seq_iter.
// Declarations only: no latency, no flow control.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_MOD  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_NOTA = 4'h7;
  localparam logic [3:0] OP_NOTB = 4'h8;
  localparam logic [3:0] OP_NAND = 4'h9;
  localparam logic [3:0] OP_NOR  = 4'hA;
  localparam logic [3:0] OP_XOR  = 4'hB;
  localparam logic [3:0] OP_XNOR = 4'hC;
  localparam logic [3:0] OP_SHL  = 4'hD;
  localparam logic [3:0] OP_SHR  = 4'hE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Shared shift-add multiplier / restoring divider, one step per cycle for WIDTH cycles.
// Latency WIDTH cycles after start; no backpressure, start restarts the engine.
module alu_seq_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,   // 0: multiply, 1: divide/modulo
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc,
  output logic [WIDTH-1:0]   rem,
  output logic               done
);

  localparam int CW = cnt_w(WIDTH);

  // acc_q upper half: partial product / partial remainder; lower half: multiplier / quotient
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               run_q, run_d;
  logic               mode_q, mode_d;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shl;
  logic [WIDTH-1:0]   diff;

  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    mode_d = mode_q;
    sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    shl    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff   = shl[WIDTH-1:0] - opnd_q;
    done   = run_q && (cnt_q == CW'(WIDTH - 1));
    if (start) begin
      mode_d = mode;
      opnd_d = mode ? b : a;
      acc_d  = {{WIDTH{1'b0}}, (mode ? a : b)};
      cnt_d  = '0;
      run_d  = 1'b1;
    end else if (run_q) begin
      cnt_d = cnt_q + CW'(1);
      if (done) run_d = 1'b0;
      if (!mode_q) begin
        acc_d = {sum, acc_q[WIDTH-1:1]};
      end else if (shl >= {1'b0, opnd_q}) begin
        acc_d = {diff, acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {shl[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      mode_q <= mode_d;
    end
  end

  assign acc = acc_q;
  assign rem = acc_q[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: 1-cycle latency for add/sub/logic, WIDTH+1 for mul/div/mod; ALU_SHIFT_EN adds SHL/SHR.
// Requests are accepted only while not busy; en during busy (including the ack cycle) is dropped.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [3:0]         sel,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] out,
  output logic               ack,
  output logic               busy,
  output logic               err,
  output logic               dz
);

  localparam int RW = 2 * WIDTH;
`ifdef ALU_SHIFT_EN
  localparam int SW = $clog2(WIDTH);
`endif

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [RW-1:0]    out_q, out_d, res;
  logic             ack_q, ack_d, err_q, err_d, dz_q, dz_d;
  logic             accept, is_iter, iter_start, iter_done, div_zero, illegal, use_lo;
  logic [RW-1:0]    iter_acc;
  logic [WIDTH-1:0] iter_rem, lo;

  assign is_iter  = (sel == OP_MUL) || (sel == OP_DIV) || (sel == OP_MOD);
  assign accept   = (state_q == IDLE) && en && !ack_q;
  assign div_zero = ((op_q == OP_DIV) || (op_q == OP_MOD)) && (b_q == '0);

  alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst   (rst),
    .start (iter_start),
    .mode  (sel != OP_MUL),
    .a     (a),
    .b     (b),
    .acc   (iter_acc),
    .rem   (iter_rem),
    .done  (iter_done)
  );

  // Logic and divide results are WIDTH wide and zero-extended through lo.
  always_comb begin
    res     = '0;
    lo      = '0;
    use_lo  = 1'b1;
    illegal = 1'b0;
    case (op_q)
      OP_ADD:  begin use_lo = 1'b0; res = {{(WIDTH-1){1'b0}}, {1'b0, a_q} + {1'b0, b_q}}; end
      OP_SUB:  begin use_lo = 1'b0; res = {{WIDTH{1'b0}}, a_q} - {{WIDTH{1'b0}}, b_q}; end
      OP_MUL:  begin use_lo = 1'b0; res = iter_acc; end
      OP_DIV:  lo = div_zero ? '1 : iter_acc[WIDTH-1:0];
      OP_MOD:  lo = div_zero ? a_q : iter_rem;
      OP_AND:  lo = a_q & b_q;
      OP_OR:   lo = a_q | b_q;
      OP_NOTA: lo = ~a_q;
      OP_NOTB: lo = ~b_q;
      OP_NAND: lo = ~(a_q & b_q);
      OP_NOR:  lo = ~(a_q | b_q);
      OP_XOR:  lo = a_q ^ b_q;
      OP_XNOR: lo = ~(a_q ^ b_q);
`ifdef ALU_SHIFT_EN
      OP_SHL:  lo = a_q << b_q[SW-1:0];
      OP_SHR:  lo = a_q >> b_q[SW-1:0];
`endif
      default: begin use_lo = 1'b0; illegal = 1'b1; end
    endcase
    if (use_lo) res = {{WIDTH{1'b0}}, lo};
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    out_d      = out_q;
    err_d      = err_q;
    dz_d       = dz_q;
    ack_d      = 1'b0;
    iter_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d = sel;
          a_d  = a;
          b_d  = b;
          if (is_iter) begin
            iter_start = 1'b1;
            state_d    = EXEC;
          end else begin
            state_d = DONE;
          end
        end
      end
      EXEC: if (iter_done) state_d = DONE;
      DONE: begin
        out_d   = res;
        err_d   = illegal;
        dz_d    = div_zero;
        ack_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dz_q    <= dz_d;
    end
  end

  assign out  = out_q;
  assign ack  = ack_q;
  assign err  = err_q;
  assign dz   = dz_q;
  assign busy = (state_q != IDLE) || ack_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq (WIDTH=32 main instance, WIDTH=8 side instance).
// A queue of expected results is filled at each accept and drained by one compare process on ack.
module tb_alu_seq;

  typedef struct packed {
    logic [127:0] out;
    logic         err;
    logic         dz;
  } exp_t;

  typedef struct {
    exp_t e;
    int   lat;
    int   acc_cyc;
  } pend_t;

  logic        clk, rst;
  logic        en, ack, busy, err, dz;
  logic [3:0]  sel;
  logic [31:0] a, b;
  logic [63:0] out;
  logic        en8, ack8, busy8, err8, dz8;
  logic [3:0]  sel8;
  logic [7:0]  a8, b8;
  logic [15:0] out8;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    last_lat = 0;
  bit    chk_on = 0;
  pend_t q[$];
  pend_t cur;
  exp_t  hold = '0;
  logic [63:0] lit [0:12];
  logic [3:0]  rs;
  logic [31:0] ra, rb;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .en(en), .sel(sel), .a(a), .b(b),
    .out(out), .ack(ack), .busy(busy), .err(err), .dz(dz)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .sel(sel8), .a(a8), .b(b8),
    .out(out8), .ack(ack8), .busy(busy8), .err(err8), .dz(dz8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain arithmetic on w-bit operands, result masked to 2w bits.
  function automatic exp_t model(input int w, input logic [3:0] s, input logic [63:0] xa, input logic [63:0] xb);
    logic [127:0] m, rm, aa, bb;
    exp_t e;
    m  = (128'd1 << w) - 1;
    rm = (128'd1 << (2 * w)) - 1;
    aa = {64'd0, xa} & m;
    bb = {64'd0, xb} & m;
    e  = '0;
    case (s)
      4'd0:  e.out = aa + bb;
      4'd1:  e.out = (aa - bb) & rm;
      4'd2:  e.out = aa * bb;
      4'd3:  if (bb == 0) begin e.out = m;  e.dz = 1'b1; end else e.out = aa / bb;
      4'd4:  if (bb == 0) begin e.out = aa; e.dz = 1'b1; end else e.out = aa % bb;
      4'd5:  e.out = aa & bb;
      4'd6:  e.out = aa | bb;
      4'd7:  e.out = ~aa & m;
      4'd8:  e.out = ~bb & m;
      4'd9:  e.out = ~(aa & bb) & m;
      4'd10: e.out = ~(aa | bb) & m;
      4'd11: e.out = aa ^ bb;
      4'd12: e.out = ~(aa ^ bb) & m;
`ifdef ALU_SHIFT_EN
      4'd13: e.out = (aa << (bb % w)) & m;
      4'd14: e.out = aa >> (bb % w);
`endif
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  function automatic int model_lat(input int w, input logic [3:0] s);
    return (s == 4'd2 || s == 4'd3 || s == 4'd4) ? w + 1 : 1;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", busy, q.size() != 0);
      if (ack === 1'b1) begin
        if (q.size() == 0) begin
          chk("spurious_ack", ack, 0);
        end else begin
          cur      = q.pop_front();
          hold     = cur.e;
          last_lat = cyc - cur.acc_cyc;
          chk("latency", last_lat, cur.lat);
        end
      end
      chk("out", out, hold.out);
      chk("err", err, hold.err);
      chk("dz",  dz,  hold.dz);
    end
  end

  task automatic issue(input logic [3:0] s, input logic [31:0] xa, input logic [31:0] xb);
    pend_t p;
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      chk("issue_wait_idle", busy, 0);
    end else begin
      en = 1'b1; sel = s; a = xa; b = xb;
      @(posedge clk);
      #1;
      p.e       = model(32, s, {32'd0, xa}, {32'd0, xb});
      p.lat     = model_lat(32, s);
      p.acc_cyc = cyc;
      q.push_back(p);
      en = 1'b0; sel = 4'($urandom); a = $urandom; b = $urandom;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("ack_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic run(input logic [3:0] s, input logic [31:0] xa, input logic [31:0] xb);
    issue(s, xa, xb);
    wait_idle();
  endtask

  // One-cycle en pulse while the unit is busy; it must be dropped.
  task automatic poke(input logic [3:0] s);
    @(negedge clk);
    if (busy === 1'b1) begin
      en = 1'b1; sel = s; a = $urandom; b = $urandom;
      @(posedge clk);
      #1 en = 1'b0;
    end
  endtask

  task automatic run8(input logic [3:0] s, input logic [7:0] xa, input logic [7:0] xb,
                      input logic [15:0] req, input int req_lat);
    int st, n;
    exp_t e;
    @(negedge clk);
    en8 = 1'b1; sel8 = s; a8 = xa; b8 = xb;
    @(posedge clk);
    #1;
    st = cyc; en8 = 1'b0;
    n = 0;
    while (ack8 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (ack8 !== 1'b1) begin
      chk("w8_ack_timeout", ack8, 1);
    end else begin
      e = model(8, s, {56'd0, xa}, {56'd0, xb});
      chk("w8_out_lit", out8, req);
      chk("w8_out_model", out8, e.out);
      chk("w8_latency", cyc - st, req_lat);
      chk("w8_err", err8, e.err);
      chk("w8_dz", dz8, e.dz);
    end
  endtask

  initial begin
    lit = '{64'hF5, 64'h33, 64'h3814, 64'h1, 64'h33, 64'h0, 64'hF5, 64'hFFFFFF6B,
            64'hFFFFFF9E, 64'hFFFFFFFF, 64'hFFFFFF0A, 64'hF5, 64'hFFFFFF0A};
    rst = 1'b1; en = 1'b0; sel = '0; a = '0; b = '0;
    en8 = 1'b0; sel8 = '0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_out", out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_dz", dz, 0);
    chk_on = 1'b1;

    // Opcode sweep with fixed operands.
    for (int s = 0; s <= 12; s++) begin
      run(4'(s), 32'h94, 32'h61);
      chk("sweep_out", out, lit[s]);
      chk("sweep_err", err, 0);
      chk("sweep_dz", dz, 0);
      if (s == 2) chk("mul_latency", last_lat, 33);
    end

    // Divide by zero and dz clearing.
    run(4'd3, 32'h94, 32'h0);
    chk("div0_out", out, 64'hFFFFFFFF);
    chk("div0_dz", dz, 1);
    chk("div0_latency", last_lat, 33);
    run(4'd4, 32'h94, 32'h0);
    chk("mod0_out", out, 64'h94);
    chk("mod0_dz", dz, 1);
    run(4'd0, 32'h1, 32'h1);
    chk("dz_clear", dz, 0);

    // Request during a multiply is ignored.
    issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (3) @(negedge clk);
    poke(4'd0);
    wait_idle();
    chk("mul_max_out", out, 64'hFFFFFFFE00000001);
    chk("mul_max_latency", last_lat, 33);

    // Reset aborts a divide; next request accepted immediately.
    issue(4'd3, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    hold = '0;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_out", out, 0);
    chk("abort_busy", busy, 0);
    run(4'd0, 32'd2, 32'd3);
    chk("post_rst_add", out, 5);
    chk("post_rst_latency", last_lat, 1);

    // Shift opcode, present only with the option.
    run(4'd13, 32'd1, 32'd4);
`ifdef ALU_SHIFT_EN
    chk("shl_out", out, 64'h10);
    chk("shl_err", err, 0);
`else
    chk("op13_out", out, 0);
    chk("op13_err", err, 1);
`endif
    run(4'd15, 32'h5, 32'h5);
    chk("op15_err", err, 1);

    // Random operations with occasional ignored requests.
    for (int i = 0; i < 150; i++) begin
      rs = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1, 2:    rb = 32'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      issue(rs, ra, rb);
      if ($urandom_range(0, 3) == 0) poke(4'($urandom_range(0, 15)));
      wait_idle();
    end

    // Narrow instance.
    run8(4'd2, 8'hFF, 8'hFF, 16'hFE01, 9);
    run8(4'd1, 8'h01, 8'h02, 16'hFFFF, 1);
    run8(4'd4, 8'd200, 8'd7, 16'd4, 9);

    repeat (2) @(negedge clk);
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
